// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice reused over N cycles, LSB first.
// Start/busy/done handshake; optional subtract via SERIAL_ADDER_SUB_EN.
//
// Ports:
//   clk, rst   clock (rising edge), async active-high reset
//   start      request, sampled in IDLE or DONE only
//   a, b, c_in operands and carry-in, captured on accepted start
//   sub        subtract select (only when SERIAL_ADDER_SUB_EN is defined)
//   busy       high while the slice is iterating
//   done       one-cycle pulse when sum/c_out are updated
//   sum, c_out result, held until the next result lands
module serial_adder_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         c_out
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic          accept;
    logic          last_bit;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-1:0]  sum_sr;
    logic [N-1:0]  sum_nx;
    logic          cy;
    logic          cy_nx;
    logic          s_bit;
    logic [CW-1:0] cnt;
    logic [N-1:0]  b_cap;
    logic          cy_cap;

    // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_cap  = sub ? ~b : b;
    assign cy_cap = sub ? 1'b1 : c_in;
`else
    assign b_cap  = b;
    assign cy_cap = c_in;
`endif

    assign last_bit = (cnt == LAST);
    assign s_bit    = a_sr[0] ^ b_sr[0] ^ cy;
    assign cy_nx    = (a_sr[0] & b_sr[0]) | (a_sr[0] & cy) | (b_sr[0] & cy);

    // New bit enters at the MSB; after N shifts bit 0 has reached sum[0].
    always_comb begin
        sum_nx        = sum_sr >> 1;
        sum_nx[N-1]   = s_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            cy     <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            c_out  <= 1'b0;
        end else if (accept) begin
            a_sr <= a;
            b_sr <= b_cap;
            cy   <= cy_cap;
            cnt  <= '0;
        end else if (state_q == S_RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            cy     <= cy_nx;
            sum_sr <= sum_nx;
            if (last_bit) begin
                sum   <= sum_nx;
                c_out <= cy_nx;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed cases plus random back-to-back adds.
// Expected results queue at start time and are checked on each done pulse.
module tb_serial_adder_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         c_out;

    logic [N:0] exp_q[$];
    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;
    int n_push = 0;

    serial_adder_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [N:0] model(input logic [N-1:0] x,
                                         input logic [N-1:0] y,
                                         input logic ci, input logic sb);
        logic [N:0] r;
        if (sb) begin
            r[N-1:0] = x - y;
            r[N]     = (x >= y);
        end else begin
            r = {1'b0, x} + {1'b0, y} + (N+1)'(ci);
        end
        return r;
    endfunction

    task automatic push(input logic [N:0] e);
        exp_q.push_back(e);
        n_push++;
    endtask

    // Scoreboard: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (done) begin
            logic [N:0] e;
            n_done++;
            if (exp_q.size() == 0) begin
                chk("sb_depth", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("sum", sum, e[N-1:0]);
                chk("c_out", c_out, e[N]);
            end
        end
    end

    // Drive one start for a single cycle, then scramble the operands.
    task automatic go(input logic [N-1:0] aa, input logic [N-1:0] bb,
                      input logic ci, input logic [N:0] e, input bit do_push);
        a     = aa;
        b     = bb;
        c_in  = ci;
        start = 1'b1;
        if (do_push) push(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
        c_in  = 1'($urandom);
    endtask

    // Count busy cycles until done, bounded; then require done to drop.
    task automatic wait_done(input string tag);
        int nb = 0;
        int k  = 0;
        do begin
            @(negedge clk);
            k++;
            if (busy) nb++;
        end while (!done && k < 3 * N);
        chk({tag, "_busy"}, nb, N);
        chk({tag, "_lat"}, k, N + 1);
        @(negedge clk);
        chk({tag, "_pulse"}, done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int d0;
        logic sb;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        sb    = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", c_out, 0);
        rst = 1'b0;
        @(negedge clk);

        go(8'h3C, 8'h42, 1'b0, 9'h07E, 1'b1);
        wait_done("add_3c42");
        go(8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
        wait_done("add_ff01");
        go(8'hFF, 8'h00, 1'b1, 9'h100, 1'b1);
        wait_done("add_ff00c");

        // Start held through RUN with changing operands.
        a     = 8'h11;
        b     = 8'h22;
        c_in  = 1'b0;
        start = 1'b1;
        push(9'h033);
        @(posedge clk);
        #1;
        a    = 8'h80;
        b    = 8'h80;
        c_in = 1'b1;
        push(9'h101);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 3 * N);
        chk("hold_first_lat", k, N + 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 3 * N);
        chk("hold_gap", k, N + 1);
        @(negedge clk);

        // Reset in the fourth RUN cycle aborts with no done.
        go(8'h55, 8'h0F, 1'b0, '0, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", c_out, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        d0 = n_done;
        repeat (3 * N) @(negedge clk);
        chk("abort_no_done", n_done, d0);

        // Reset wins over a simultaneous start.
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h01;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", busy, 0);

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        go(8'h10, 8'h01, 1'b0, 9'h10F, 1'b1);
        wait_done("sub_1001");
        go(8'h01, 8'h02, 1'b1, 9'h0FF, 1'b1);
        wait_done("sub_0102");
        sub = 1'b0;
`endif

        // Random back-to-back adds: start stays high, one capture per N+1.
        start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a    = N'($urandom);
            b    = N'($urandom);
            c_in = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sub = 1'($urandom);
            sb  = sub;
`endif
            push(model(a, b, c_in, sb));
            @(posedge clk);
            #1;
            a    = N'($urandom);
            b    = N'($urandom);
            c_in = 1'($urandom);
            repeat (N) @(posedge clk);
            #1;
        end
        start = 1'b0;
        k = 0;
        while (exp_q.size() > 0 && k < 4 * N) begin
            @(negedge clk);
            k++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        chk("done_count", n_done, n_push);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
